// File: rtl/extram_arbiter_pkg.sv
// extram_arbiter_pkg: slot-state encoding and SRAM geometry shared by the external-RAM arbiter.
package extram_arbiter_pkg;

    localparam int SRAM_ADR_WIDTH = 19;
    localparam int SRAM_DAT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        VGA_RD = 2'd1,
        CPU_RD = 2'd2,
        CPU_WR = 2'd3
    } slot_t;

    function automatic logic is_cpu(input slot_t s);
        return (s == CPU_RD) || (s == CPU_WR);
    endfunction

endpackage

// File: rtl/extram_arbiter.sv
// extram_arbiter: one SRAM slot per cycle; VGA reads have absolute priority,
// CPU Wishbone byte accesses fill the slots the VGA leaves free.
module extram_arbiter
    import extram_arbiter_pkg::*;
#(
    parameter int ADR_WIDTH = SRAM_ADR_WIDTH,
    parameter int DAT_WIDTH = SRAM_DAT_WIDTH
) (
    input  logic                 I_clk,
    input  logic                 I_reset,
    input  logic                 I_vga_req,
    input  logic [ADR_WIDTH-1:0] I_vga_adr,
    output logic [DAT_WIDTH-1:0] O_vga_dat,
    output logic                 O_vga_overrun,
    input  logic [ADR_WIDTH-1:0] I_wb_adr,
    input  logic [DAT_WIDTH-1:0] I_wb_dat,
    input  logic                 I_wb_stb,
    input  logic                 I_wb_we,
    output logic                 O_wb_ack,
    output logic [DAT_WIDTH-1:0] O_wb_dat,
    output logic [ADR_WIDTH-1:0] O_sram_adr,
    input  logic [DAT_WIDTH-1:0] I_sram_dat,
    output logic [DAT_WIDTH-1:0] O_sram_dat,
    output logic                 O_sram_dat_oe,
    output logic                 O_sram_we_n,
    output logic                 O_sram_oe_n
);

    slot_t                slot;
    logic                 vga_req_q;
    logic [DAT_WIDTH-1:0] vga_hold;
    logic                 cpu_start;

    // A strobe still high while ack is out, or while its own slot runs, is not served again
    assign cpu_start = !I_vga_req && I_wb_stb && !O_wb_ack && !is_cpu(slot);
    assign O_vga_dat = (slot == VGA_RD) ? I_sram_dat : vga_hold;

    always_ff @(posedge I_clk or posedge I_reset) begin
        if (I_reset) begin
            slot          <= IDLE;
            vga_req_q     <= 1'b0;
            vga_hold      <= '0;
            O_vga_overrun <= 1'b0;
            O_wb_ack      <= 1'b0;
            O_wb_dat      <= '0;
            O_sram_adr    <= '0;
            O_sram_dat    <= '0;
            O_sram_dat_oe <= 1'b0;
            O_sram_we_n   <= 1'b1;
            O_sram_oe_n   <= 1'b0;
        end else begin
            vga_req_q     <= I_vga_req;
            O_vga_overrun <= O_vga_overrun | (I_vga_req & vga_req_q);
            O_wb_ack      <= is_cpu(slot);
            if (slot == CPU_RD)
                O_wb_dat <= I_sram_dat;
            if (slot == VGA_RD)
                vga_hold <= I_sram_dat;
            if (I_vga_req) begin
                slot          <= VGA_RD;
                O_sram_adr    <= I_vga_adr;
                O_sram_oe_n   <= 1'b0;
                O_sram_we_n   <= 1'b1;
                O_sram_dat_oe <= 1'b0;
            end else if (cpu_start) begin
                slot          <= I_wb_we ? CPU_WR : CPU_RD;
                O_sram_adr    <= I_wb_adr;
                O_sram_oe_n   <= I_wb_we;
                O_sram_we_n   <= !I_wb_we;
                O_sram_dat_oe <= I_wb_we;
                if (I_wb_we)
                    O_sram_dat <= I_wb_dat;
            end else begin
                slot          <= IDLE;
                O_sram_oe_n   <= 1'b0;
                O_sram_we_n   <= 1'b1;
                O_sram_dat_oe <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_extram_arbiter.sv
// tb_extram_arbiter: directed checks of the SRAM arbiter against a behavioural async SRAM.
module tb_extram_arbiter;

    logic        I_clk;
    logic        I_reset;
    logic        I_vga_req;
    logic [18:0] I_vga_adr;
    logic [7:0]  O_vga_dat;
    logic        O_vga_overrun;
    logic [18:0] I_wb_adr;
    logic [7:0]  I_wb_dat;
    logic        I_wb_stb;
    logic        I_wb_we;
    logic        O_wb_ack;
    logic [7:0]  O_wb_dat;
    logic [18:0] O_sram_adr;
    logic [7:0]  I_sram_dat;
    logic [7:0]  O_sram_dat;
    logic        O_sram_dat_oe;
    logic        O_sram_we_n;
    logic        O_sram_oe_n;

    int vectors = 0;
    int miscompares = 0;
    int acks = 0;

    logic [7:0] mem [0:524287];

    extram_arbiter dut (
        .I_clk(I_clk), .I_reset(I_reset),
        .I_vga_req(I_vga_req), .I_vga_adr(I_vga_adr), .O_vga_dat(O_vga_dat),
        .O_vga_overrun(O_vga_overrun),
        .I_wb_adr(I_wb_adr), .I_wb_dat(I_wb_dat), .I_wb_stb(I_wb_stb), .I_wb_we(I_wb_we),
        .O_wb_ack(O_wb_ack), .O_wb_dat(O_wb_dat),
        .O_sram_adr(O_sram_adr), .I_sram_dat(I_sram_dat), .O_sram_dat(O_sram_dat),
        .O_sram_dat_oe(O_sram_dat_oe), .O_sram_we_n(O_sram_we_n), .O_sram_oe_n(O_sram_oe_n)
    );

    initial I_clk = 1'b0;
    always #5 I_clk = ~I_clk;

    // Async SRAM: combinational read, write committed at the edge ending a we_n-low slot
    assign I_sram_dat = mem[O_sram_adr];
    always @(posedge I_clk)
        if (!O_sram_we_n)
            mem[O_sram_adr] <= O_sram_dat;

    function automatic logic [7:0] f(input logic [18:0] a);
        return a[7:0] ^ 8'h5A;
    endfunction

    task automatic tick();
        @(posedge I_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        for (int i = 0; i < 524288; i++) mem[i] = f(19'(i));
        mem[19'h20000] = 8'hA5;
        I_reset = 1'b1; I_vga_req = 1'b0; I_vga_adr = '0;
        I_wb_adr = '0; I_wb_dat = '0; I_wb_stb = 1'b0; I_wb_we = 1'b0;
        tick(); tick();
        chk("rst_adr", 32'(O_sram_adr), 0);
        chk("rst_sdat", 32'(O_sram_dat), 0);
        chk("rst_oe", 32'(O_sram_dat_oe), 0);
        chk("rst_we_n", 32'(O_sram_we_n), 1);
        chk("rst_oe_n", 32'(O_sram_oe_n), 0);
        chk("rst_ack", 32'(O_wb_ack), 0);
        chk("rst_wbdat", 32'(O_wb_dat), 0);
        chk("rst_ovr", 32'(O_vga_overrun), 0);
        I_reset = 1'b0;
        tick();

        // VGA read
        I_vga_req = 1'b1; I_vga_adr = 19'h20000;
        tick();
        I_vga_req = 1'b0;
        chk("vga_adr", 32'(O_sram_adr), 32'h20000);
        chk("vga_oe_n", 32'(O_sram_oe_n), 0);
        chk("vga_dat_slot", 32'(O_vga_dat), 32'hA5);
        tick();
        chk("vga_dat_hold", 32'(O_vga_dat), 32'hA5);

        // CPU write, strobe held through ack to check there is no second write
        I_wb_stb = 1'b1; I_wb_we = 1'b1; I_wb_adr = 19'h00010; I_wb_dat = 8'h3C;
        tick();
        chk("wr_we_n", 32'(O_sram_we_n), 0);
        chk("wr_dat_oe", 32'(O_sram_dat_oe), 1);
        chk("wr_oe_n", 32'(O_sram_oe_n), 1);
        chk("wr_sdat", 32'(O_sram_dat), 32'h3C);
        chk("wr_adr", 32'(O_sram_adr), 32'h10);
        chk("wr_ack_early", 32'(O_wb_ack), 0);
        tick();
        chk("wr_ack", 32'(O_wb_ack), 1);
        chk("wr_we_n_off", 32'(O_sram_we_n), 1);
        chk("wr_dat_oe_off", 32'(O_sram_dat_oe), 0);
        tick();
        chk("wr_no_double_we", 32'(O_sram_we_n), 1);
        chk("wr_ack_pulse", 32'(O_wb_ack), 0);
        I_wb_stb = 1'b0;
        tick();

        // CPU read back
        I_wb_stb = 1'b1; I_wb_we = 1'b0; I_wb_adr = 19'h00010;
        tick();
        chk("rd_adr", 32'(O_sram_adr), 32'h10);
        chk("rd_we_n", 32'(O_sram_we_n), 1);
        tick();
        chk("rd_ack", 32'(O_wb_ack), 1);
        chk("rd_dat", 32'(O_wb_dat), 32'h3C);
        I_wb_stb = 1'b0;
        tick();
        chk("rd_ack_off", 32'(O_wb_ack), 0);

        // Contention: VGA slot first, CPU slot next
        I_wb_stb = 1'b1; I_wb_we = 1'b0; I_wb_adr = 19'h00010;
        I_vga_req = 1'b1; I_vga_adr = 19'h20000;
        tick();
        I_vga_req = 1'b0;
        chk("con_vga_adr", 32'(O_sram_adr), 32'h20000);
        chk("con_vga_dat", 32'(O_vga_dat), 32'hA5);
        chk("con_ack0", 32'(O_wb_ack), 0);
        tick();
        chk("con_cpu_adr", 32'(O_sram_adr), 32'h10);
        chk("con_vga_hold", 32'(O_vga_dat), 32'hA5);
        tick();
        chk("con_ack", 32'(O_wb_ack), 1);
        chk("con_dat", 32'(O_wb_dat), 32'h3C);
        I_wb_stb = 1'b0;
        tick();

        // Graphics cadence with continuous CPU writes
        I_wb_stb = 1'b1; I_wb_we = 1'b1; I_wb_adr = 19'h00200; I_wb_dat = 8'h00;
        for (int c = 0; c < 640; c++) begin
            I_vga_req = (c % 2 == 0);
            I_vga_adr = 19'h40000 + 19'(c);
            tick();
            if (c % 2 == 1)
                chk("cad_vga", 32'(O_vga_dat), 32'(f(19'h40000 + 19'(c - 1))));
            if (O_wb_ack) begin
                acks++;
                I_wb_adr = I_wb_adr + 19'd1;
                I_wb_dat = I_wb_dat + 8'd1;
            end
        end
        I_vga_req = 1'b0; I_wb_stb = 1'b0;
        tick(); tick();
        chk("cad_acks", 32'(acks), 160);
        chk("cad_ovr", 32'(O_vga_overrun), 0);
        chk("cad_mem_first", 32'(mem[19'h00200]), 32'h00);
        chk("cad_mem_last", 32'(mem[19'h00200 + 19'd159]), 32'h9F);

        // Overrun: back-to-back VGA requests
        I_vga_req = 1'b1; I_vga_adr = 19'h00100;
        tick();
        chk("ovr_first_dat", 32'(O_vga_dat), 32'h5A);
        chk("ovr_not_yet", 32'(O_vga_overrun), 0);
        I_vga_adr = 19'h00101;
        tick();
        I_vga_req = 1'b0;
        chk("ovr_second_dat", 32'(O_vga_dat), 32'h5B);
        chk("ovr_set", 32'(O_vga_overrun), 1);
        tick();
        chk("ovr_hold_dat", 32'(O_vga_dat), 32'h5B);
        tick(); tick();
        chk("ovr_sticky", 32'(O_vga_overrun), 1);

        // Reset in the middle of a CPU write slot
        I_wb_stb = 1'b1; I_wb_we = 1'b1; I_wb_adr = 19'h00300; I_wb_dat = 8'h77;
        tick();
        chk("mid_we_n_low", 32'(O_sram_we_n), 0);
        #2 I_reset = 1'b1;
        #1;
        chk("mid_we_n_async", 32'(O_sram_we_n), 1);
        chk("mid_dat_oe_async", 32'(O_sram_dat_oe), 0);
        tick();
        chk("mid_ack", 32'(O_wb_ack), 0);
        chk("mid_adr", 32'(O_sram_adr), 0);
        chk("mid_sdat", 32'(O_sram_dat), 0);
        chk("mid_oe_n", 32'(O_sram_oe_n), 0);
        chk("mid_ovr_clr", 32'(O_vga_overrun), 0);
        chk("mid_wbdat", 32'(O_wb_dat), 0);
        chk("mid_mem_untouched", 32'(mem[19'h00300]), 32'h5A);
        I_wb_stb = 1'b0;
        I_reset = 1'b0;
        tick();
        chk("mid_no_ack", 32'(O_wb_ack), 0);
        I_wb_stb = 1'b1;
        tick();
        chk("re_we_n", 32'(O_sram_we_n), 0);
        tick();
        chk("re_ack", 32'(O_wb_ack), 1);
        I_wb_stb = 1'b0;
        tick();
        chk("re_mem", 32'(mem[19'h00300]), 32'h77);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
